// File: rtl/corefifo_pkg.sv
// Shared CoreFIFO constants and Gray/binary helpers.
// Used by both the write-side and read-side pointer controllers.
package corefifo_pkg;

    localparam int CF_ADDRWIDTH = 3;
    localparam int CF_DEPTH     = 2 ** CF_ADDRWIDTH;
    localparam int CF_PTR_W     = CF_ADDRWIDTH + 1;
    localparam int CF_AFULL_VAL = 6;

    // Width-agnostic: callers zero-extend into 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/corefifo_wr_ptr_ctrl_if.sv
// Write-side pointer link: producer request, synced read pointer,
// and the RAM-enable / pointer / flag outputs of the controller.
interface corefifo_wr_ptr_ctrl_if #(
    parameter int ADDRWIDTH = 3
);

    logic                 we;
    logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
    logic                 wen_mem;
    logic [ADDRWIDTH-1:0] waddr;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wr_cnt;
    logic                 overflow;

    modport master (
        output we,
        output rd_ptr_gray_sync,
        input  wen_mem,
        input  waddr,
        input  wr_ptr_gray,
        input  full,
        input  afull,
        input  wr_cnt,
        input  overflow
    );

    modport slave (
        input  we,
        input  rd_ptr_gray_sync,
        output wen_mem,
        output waddr,
        output wr_ptr_gray,
        output full,
        output afull,
        output wr_cnt,
        output overflow
    );

endinterface

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary converter: bit i is the XOR of all
// Gray bits from the MSB down to i.
module corefifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/corefifo_wr_ptr_ctrl.sv
// CoreFIFO write-side pointer controller: qualifies RAM writes, owns the
// write pointer, publishes it in Gray, and derives full/afull/count.
module corefifo_wr_ptr_ctrl
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = CF_ADDRWIDTH,
    parameter int AFULL_VAL = CF_AFULL_VAL
) (
    input  logic                   clk,
    input  logic                   rst,
    corefifo_wr_ptr_ctrl_if.slave  wif
);

    localparam int PW    = ADDRWIDTH + 1;
    localparam int DEPTH = 2 ** ADDRWIDTH;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_VAL);

    logic [PW-1:0] wr_bin_q;
    logic [PW-1:0] wr_bin_d;
    logic [PW-1:0] wr_gray_q;
    logic [PW-1:0] wr_gray_d;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] rd_bin;
    logic          full_q;
    logic          full_d;
    logic          afull_q;
    logic          afull_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          acc;

    corefifo_gray2bin #(
        .W (PW)
    ) u_rd_g2b (
        .gray_i (wif.rd_ptr_gray_sync),
        .bin_o  (rd_bin)
    );

    // Full is the registered flag, so a write seen while full is blocked
    // even if the read pointer frees space in that same cycle.
    always_comb begin
        acc       = wif.we & ~full_q;
        wr_bin_d  = wr_bin_q + PW'(acc);
        wr_gray_d = PW'(bin2gray(32'(wr_bin_d)));
        cnt_d     = wr_bin_d - rd_bin;
        full_d    = (cnt_d == DEPTH_P);
        afull_d   = (cnt_d >= AFULL_P);
        ovf_d     = wif.we & full_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wif.wen_mem     = acc;
    assign wif.waddr       = wr_bin_q[ADDRWIDTH-1:0];
    assign wif.wr_ptr_gray = wr_gray_q;
    assign wif.full        = full_q;
    assign wif.afull       = afull_q;
    assign wif.wr_cnt      = cnt_q;
    assign wif.overflow    = ovf_q;

endmodule
